sram_access_ctrl: RTL and testbench
===================================

Name: sram_access_ctrl

Overview:
Initiator-side sequencer for the 128-row dual-read/single-write IMC SRAM macro. It accepts operation requests on a valid/ready interface and drives the row decoder's address and enable inputs with correct phasing. It captures read bitline data and returns it on a valid/ready response channel. It never issues write_enable together with both read enables, because the decoder suppresses that write.

Parameters:
ADDR_W, 7, row address width (ROWS = 2**ADDR_W)
DATA_W, 32, word width of array read/write data

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_op  in  2  00 READ1, 01 READ2, 10 WRITE, 11 RW (read addr_a, write addr_b)
req_addr_a  in  ADDR_W  read address 1 / write address for WRITE
req_addr_b  in  ADDR_W  read address 2 (READ2) / write address (RW)
req_wdata  in  DATA_W  write data
read_address1  out  ADDR_W  to decoder
read_address2  out  ADDR_W  to decoder
read_enable1  out  1  to decoder
read_enable2  out  1  to decoder
write_address  out  ADDR_W  to decoder
write_enable  out  1  to decoder
arr_wdata  out  DATA_W  write bitline data
arr_rdata1  in  DATA_W  read port 1 sense data, valid the cycle after the read enable
arr_rdata2  in  DATA_W  read port 2 sense data
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata1  out  DATA_W  port 1 data (0 for WRITE)
rsp_rdata2  out  DATA_W  port 2 data (0 unless READ2)

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. All decoder outputs, arr_wdata, rsp_* = 0. req_ready=0 while rst_n=0. Reset mid-operation aborts with no response; enables drop at the next edge.
- All outputs are registered. Decoder addresses and arr_wdata are 0 whenever their enable is 0.
- FSM states: IDLE, ISSUE_R, SENSE, ISSUE_W, RESP.
- IDLE: req_ready=1. On accept, latch op, addresses and wdata.
  - READ1/READ2/RW go to ISSUE_R.
  - WRITE goes to ISSUE_W.
- ISSUE_R (one cycle):
  - read_enable1=1 with read_address1=addr_a.
  - READ2 also asserts read_enable2=1 with read_address2=addr_b.
  - Next state: SENSE.
- SENSE (one cycle): capture arr_rdata1 (and arr_rdata2 for READ2). Next state is ISSUE_W for RW, otherwise RESP.
- ISSUE_W (one cycle):
  - write_enable=1, arr_wdata=wdata.
  - write_address = addr_a for WRITE, addr_b for RW.
  - Next state: RESP.
- RESP: rsp_valid=1, data held stable until rsp_ready. On handshake go to IDLE; req_ready rises the following cycle. rsp_rdata for an RW holds the pre-write read value.
- Latency, from accept edge T:
  - READ1/READ2: enable high during T+1, rsp_valid from T+3.
  - WRITE: write_enable high during T+1, rsp_valid from T+2.
  - RW (split): rsp_valid from T+4.
- READ2 with addr_a==addr_b is legal: both enables assert on the same row and both rdata fields return the same word.
- Invariant: read_enable1 & read_enable2 & write_enable is never 1.
- Only one outstanding op exists; req_ready=0 outside IDLE.

Optional Feature:
SRAM_RW_FUSE_EN
- Defined: an RW op with addr_a != addr_b is fused. ISSUE_R asserts read_enable1 and write_enable in the same cycle; this is decoder-legal because read_enable2=0. SENSE then goes directly to RESP, giving rsp_valid from T+3.
- RW with addr_a == addr_b always uses the split path.
- Undefined: RW is always split read-then-write.

Decomposition:
- Package sram_ctrl_pkg holds:
  - ADDR_W/DATA_W defaults
  - op_e enum {OP_READ1, OP_READ2, OP_WRITE, OP_RW}
  - state_e enum
  - request struct (op, addr_a, addr_b, wdata)
- No sub-module needed; a single FSM module is sufficient.

Test Plan:
- Reset then READ1 addr_a=5, arr_rdata1=0xDEADBEEF at T+2 -> read_enable1=1, read_address1=5 during T+1 only; rsp_valid at T+3 with rsp_rdata1=0xDEADBEEF, rsp_rdata2=0.
- WRITE addr_a=127 wdata=0xA5A5A5A5 -> write_enable=1, write_address=127, arr_wdata=0xA5A5A5A5 during T+1; rsp_valid at T+2; all enables 0 otherwise.
- READ2 addr 3 and 3, rdata 0x11/0x11 -> both enables high in one cycle; response 0x11/0x11.
- RW addr_a=10 addr_b=20 -> no fuse: read cycle T+1, write cycle T+3, rsp at T+4; with SRAM_RW_FUSE_EN: read_enable1 and write_enable both high at T+1, rsp at T+3; a monitor checks the triple-enable invariant on every cycle.
- rsp_ready held 0 for 5 cycles -> rsp_valid/data stable, req_ready=0, no new decoder activity.
- rst_n low during ISSUE_R of a READ2 -> next edge all outputs 0, state IDLE, no rsp_valid; a subsequent WRITE completes normally.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types for the IMC SRAM access sequencer: default widths, operation
// codes, FSM states and the latched request record.
package sram_ctrl_pkg;

    localparam int unsigned SRAM_ADDR_W = 7;
    localparam int unsigned SRAM_DATA_W = 32;

    typedef enum logic [1:0] {
        OP_READ1 = 2'b00,
        OP_READ2 = 2'b01,
        OP_WRITE = 2'b10,
        OP_RW    = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StIssueR,
        StSense,
        StIssueW,
        StResp
    } state_e;

    // Field widths track the package defaults; the top is built with matching parameters.
    typedef struct packed {
        op_e                    op;
        logic [SRAM_ADDR_W-1:0] addr_a;
        logic [SRAM_ADDR_W-1:0] addr_b;
        logic [SRAM_DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/sram_access_ctrl.sv
// Initiator-side sequencer for the dual-read/single-write IMC SRAM macro.
// Accepts one request at a time, phases the row-decoder enables, captures the
// sensed read data and returns it on a valid/ready response channel.
// Optional build macro SRAM_RW_FUSE_EN: fuses an RW op with distinct
// addresses into a single read+write issue cycle.
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = SRAM_ADDR_W,
    parameter int unsigned DATA_W = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr_a,
    input  logic [ADDR_W-1:0] req_addr_b,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] read_address1,
    output logic [ADDR_W-1:0] read_address2,
    output logic              read_enable1,
    output logic              read_enable2,
    output logic [ADDR_W-1:0] write_address,
    output logic              write_enable,
    output logic [DATA_W-1:0] arr_wdata,
    input  logic [DATA_W-1:0] arr_rdata1,
    input  logic [DATA_W-1:0] arr_rdata2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata1,
    output logic [DATA_W-1:0] rsp_rdata2
);

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic              fuse_q, fuse_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;

    // Registered outputs, computed from the next state so they line up with it.
    logic              rdy_q, rdy_d;
    logic              re1_q, re1_d;
    logic              re2_q, re2_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] ra1_q, ra1_d;
    logic [ADDR_W-1:0] ra2_q, ra2_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp1_q, rsp1_d;
    logic [DATA_W-1:0] rsp2_q, rsp2_d;

    // Next-state logic: request latch, read-data capture and FSM sequencing.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        fuse_d  = fuse_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    req_d.op     = op_e'(req_op);
                    req_d.addr_a = req_addr_a;
                    req_d.addr_b = req_addr_b;
                    req_d.wdata  = req_wdata;
                    rd1_d        = '0;
                    rd2_d        = '0;
`ifdef SRAM_RW_FUSE_EN
                    // Same-row RW must stay split: the read has to see pre-write data.
                    fuse_d = (op_e'(req_op) == OP_RW) && (req_addr_a != req_addr_b);
`else
                    fuse_d = 1'b0;
`endif
                    state_d = (op_e'(req_op) == OP_WRITE) ? StIssueW : StIssueR;
                end
            end
            StIssueR: state_d = StSense;
            StSense: begin
                rd1_d   = arr_rdata1;
                rd2_d   = (req_q.op == OP_READ2) ? arr_rdata2 : '0;
                state_d = (req_q.op == OP_RW && !fuse_q) ? StIssueW : StResp;
            end
            StIssueW: state_d = StResp;
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode for the state being entered; addresses and data stay 0 unless enabled.
    always_comb begin
        rdy_d       = 1'b0;
        re1_d       = 1'b0;
        re2_d       = 1'b0;
        we_d        = 1'b0;
        ra1_d       = '0;
        ra2_d       = '0;
        wa_d        = '0;
        wdata_d     = '0;
        rsp_valid_d = 1'b0;
        rsp1_d      = '0;
        rsp2_d      = '0;
        unique case (state_d)
            StIdle: rdy_d = 1'b1;
            StIssueR: begin
                re1_d = 1'b1;
                ra1_d = req_d.addr_a;
                if (req_d.op == OP_READ2) begin
                    re2_d = 1'b1;
                    ra2_d = req_d.addr_b;
                end
                // Read port 2 is idle here, so the decoder honours the write.
                if (fuse_d) begin
                    we_d    = 1'b1;
                    wa_d    = req_d.addr_b;
                    wdata_d = req_d.wdata;
                end
            end
            StSense: begin
            end
            StIssueW: begin
                we_d    = 1'b1;
                wa_d    = (req_d.op == OP_WRITE) ? req_d.addr_a : req_d.addr_b;
                wdata_d = req_d.wdata;
            end
            StResp: begin
                rsp_valid_d = 1'b1;
                rsp1_d      = rd1_d;
                rsp2_d      = rd2_d;
            end
            default: begin
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            req_q       <= '0;
            fuse_q      <= 1'b0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            rdy_q       <= 1'b1;
            re1_q       <= 1'b0;
            re2_q       <= 1'b0;
            we_q        <= 1'b0;
            ra1_q       <= '0;
            ra2_q       <= '0;
            wa_q        <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp1_q      <= '0;
            rsp2_q      <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            fuse_q      <= fuse_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            rdy_q       <= rdy_d;
            re1_q       <= re1_d;
            re2_q       <= re2_d;
            we_q        <= we_d;
            ra1_q       <= ra1_d;
            ra2_q       <= ra2_d;
            wa_q        <= wa_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp1_q      <= rsp1_d;
            rsp2_q      <= rsp2_d;
        end
    end

    // Ready is masked while reset is held so nothing is accepted during reset.
    assign req_ready     = rdy_q & rst_n;
    assign read_enable1  = re1_q;
    assign read_enable2  = re2_q;
    assign write_enable  = we_q;
    assign read_address1 = ra1_q;
    assign read_address2 = ra2_q;
    assign write_address = wa_q;
    assign arr_wdata     = wdata_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata1    = rsp1_q;
    assign rsp_rdata2    = rsp2_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Self-checking bench for sram_access_ctrl: vector table of operations with
// per-cycle decoder expectations, response scoreboard, stall and reset-abort
// sequences, and a triple-enable monitor. Honours SRAM_RW_FUSE_EN.
module tb_sram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [6:0]  req_addr_a;
    logic [6:0]  req_addr_b;
    logic [31:0] req_wdata;
    logic [6:0]  read_address1;
    logic [6:0]  read_address2;
    logic        read_enable1;
    logic        read_enable2;
    logic [6:0]  write_address;
    logic        write_enable;
    logic [31:0] arr_wdata;
    logic [31:0] arr_rdata1;
    logic [31:0] arr_rdata2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata1;
    logic [31:0] rsp_rdata2;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  a;
        logic [6:0]  b;
        logic [31:0] wd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t        vecs[7];
    logic [63:0] sb_q[$];

`ifdef SRAM_RW_FUSE_EN
    localparam bit FuseOn = 1'b1;
`else
    localparam bit FuseOn = 1'b0;
`endif

    sram_access_ctrl #(
        .ADDR_W(7),
        .DATA_W(32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr_a   (req_addr_a),
        .req_addr_b   (req_addr_b),
        .req_wdata    (req_wdata),
        .read_address1(read_address1),
        .read_address2(read_address2),
        .read_enable1 (read_enable1),
        .read_enable2 (read_enable2),
        .write_address(write_address),
        .write_enable (write_enable),
        .arr_wdata    (arr_wdata),
        .arr_rdata1   (arr_rdata1),
        .arr_rdata2   (arr_rdata2),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata1   (rsp_rdata1),
        .rsp_rdata2   (rsp_rdata2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // {pad, re1, re2, we, ra1, ra2, wa, arr_wdata, rsp_valid, req_ready}
    function automatic logic [63:0] dut_vec();
        return {6'b0, read_enable1, read_enable2, write_enable, read_address1, read_address2,
                write_address, arr_wdata, rsp_valid, req_ready};
    endfunction

    function automatic int latency(input logic [1:0] op, input bit fused);
        if (op == 2'b10) return 2;
        if (op == 2'b11) return fused ? 3 : 4;
        return 3;
    endfunction

    // Expected outputs in cycle k after the accept edge.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [6:0] a,
                                          input logic [6:0] b, input logic [31:0] wd,
                                          input int k, input int lat, input int stall,
                                          input bit fused);
        logic re1, re2, we, rv, rdy;
        logic [6:0] ra1, ra2, wa;
        logic [31:0] wdat;
        re1 = 0; re2 = 0; we = 0; ra1 = 0; ra2 = 0; wa = 0; wdat = 0;
        if (k == 1 && op != 2'b10) begin re1 = 1; ra1 = a; end
        if (k == 1 && op == 2'b01) begin re2 = 1; ra2 = b; end
        if (k == 1 && op == 2'b10) begin we = 1; wa = a; wdat = wd; end
        if (op == 2'b11 && ((fused && k == 1) || (!fused && k == 3))) begin
            we = 1; wa = b; wdat = wd;
        end
        rv  = (k >= lat) && (k <= lat + stall);
        rdy = (k == lat + stall + 1);
        return {6'b0, re1, re2, we, ra1, ra2, wa, wdat, rv, rdy};
    endfunction

    // Issue one op starting just after a posedge; returns just after a posedge in IDLE.
    task automatic run_op(input string tag, input vec_t v, input int stall);
        int lat;
        bit fused;
        fused = FuseOn && v.op == 2'b11 && v.a != v.b;
        lat   = latency(v.op, fused);
        chk({tag, "_ready_pre"}, {63'b0, req_ready}, 64'd1);
        req_valid  = 1'b1;
        req_op     = v.op;
        req_addr_a = v.a;
        req_addr_b = v.b;
        req_wdata  = v.wd;
        rsp_ready  = (stall == 0);
        @(posedge clk);
        sb_q.push_back({v.e1, v.e2});
        #1;
        for (int k = 1; k <= lat + stall + 1; k++) begin
            req_valid = (stall > 0) && (k >= 2) && (k <= lat + stall);
            if (req_valid) begin
                req_op     = 2'b10;
                req_addr_a = 7'h55;
                req_wdata  = 32'h0BAD_0BAD;
            end
            arr_rdata1 = (k == 2) ? v.rd1 : (32'hBAD0_0000 | 32'(k));
            arr_rdata2 = (k == 2) ? v.rd2 : (32'hBAD1_0000 | 32'(k));
            if (k == lat + stall) rsp_ready = 1'b1;
            @(negedge clk);
            chk({tag, "_dec"}, dut_vec(), model(v.op, v.a, v.b, v.wd, k, lat, stall, fused));
            if (k >= lat && k <= lat + stall)
                chk({tag, "_rsp_hold"}, {rsp_rdata1, rsp_rdata2}, {v.e1, v.e2});
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: compare each response at its handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL sb_unexpected_rsp @%0t: got %h/%h expected none", $time,
                         rsp_rdata1, rsp_rdata2);
            end else begin
                chk("sb_rsp", {rsp_rdata1, rsp_rdata2}, sb_q.pop_front());
            end
        end
    end

    // The decoder drops a write issued alongside both reads.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if ((read_enable1 & read_enable2 & write_enable) !== 1'b0) begin
                fails++;
                $display("FAIL triple_enable @%0t: got %b%b%b expected not 111", $time,
                         read_enable1, read_enable2, write_enable);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog @%0t: got timeout expected end of test", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b00, 7'd5,   7'd9,   32'h0,        32'hDEADBEEF, 32'h12345678,
                    32'hDEADBEEF, 32'h0};
        vecs[1] = '{2'b10, 7'd127, 7'd3,   32'hA5A5A5A5, 32'h11112222, 32'h33334444,
                    32'h0,        32'h0};
        vecs[2] = '{2'b01, 7'd3,   7'd3,   32'h0,        32'h00000011, 32'h00000011,
                    32'h00000011, 32'h00000011};
        vecs[3] = '{2'b11, 7'd10,  7'd20,  32'hCAFEF00D, 32'h5555AAAA, 32'h00000077,
                    32'h5555AAAA, 32'h0};
        vecs[4] = '{2'b01, 7'd0,   7'd127, 32'h0,        32'h0F0F0F0F, 32'hF0F0F0F0,
                    32'h0F0F0F0F, 32'hF0F0F0F0};
        vecs[5] = '{2'b11, 7'd33,  7'd33,  32'h00000001, 32'h0BADC0DE, 32'h99999999,
                    32'h0BADC0DE, 32'h0};
        vecs[6] = '{2'b10, 7'd0,   7'd64,  32'hFFFFFFFF, 32'h0,        32'h0,
                    32'h0,        32'h0};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_addr_a = '0;
        req_addr_b = '0;
        req_wdata  = '0;
        arr_rdata1 = 32'hBAD0_0000;
        arr_rdata2 = 32'hBAD1_0000;
        rsp_ready  = 1'b1;

        // Reset state: all zero, ready masked while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", dut_vec(), 64'd0);
        chk("reset_rsp_data", {rsp_rdata1, rsp_rdata2}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_release", dut_vec(), 64'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) run_op($sformatf("vec%0d", i), vecs[i], 0);

        // Response back-pressure for 5 cycles with a competing request presented.
        run_op("stall", '{2'b00, 7'd42, 7'd0, 32'h0, 32'h13579BDF, 32'h2468ACE0,
                          32'h13579BDF, 32'h0}, 5);

        // Reset asserted during the read-issue cycle of a READ2.
        req_valid  = 1'b1;
        req_op     = 2'b01;
        req_addr_a = 7'd8;
        req_addr_b = 7'd9;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        chk("abort_issue", dut_vec(), model(2'b01, 7'd8, 7'd9, 32'h0, 1, 3, 0, 1'b0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_in_reset", dut_vec(), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_quiet", dut_vec(), 64'd1);
            @(posedge clk);
            #1;
        end
        run_op("post_abort_write", vecs[1], 0);

        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
